// File: rtl/fuzz_program_loader_pkg.sv
// Shared definitions for the fuzz harness program loader: opcodes,
// load status codes and loader state encoding.
package fuzz_program_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    // Fuzz ISA opcodes (bits [31:24] of an instruction word)
    localparam logic [BYTE_W-1:0] OP_PNEW     = 8'h00;
    localparam logic [BYTE_W-1:0] OP_XOR_LOAD = 8'h0A;
    localparam logic [BYTE_W-1:0] OP_XOR_ADD  = 8'h0B;
    localparam logic [BYTE_W-1:0] OP_XOR_SWAP = 8'h0C;
    localparam logic [BYTE_W-1:0] OP_EMIT     = 8'h0E;
    localparam logic [BYTE_W-1:0] OP_HALT     = 8'hFF;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_PARTIAL  = 2'd1,
        ERR_OVERFLOW = 2'd2
    } load_err_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } load_state_e;

    function automatic logic is_halt(input logic [WORD_W-1:0] w);
        return w[WORD_W-1 -: BYTE_W] == OP_HALT;
    endfunction

endpackage

// File: rtl/fuzz_word_assembler.sv
// Packs accepted stream bytes into 32-bit big-endian words. word_vld_o is a
// combinational pulse in the cycle the fourth byte is accepted, so the
// caller can register the memory write on that same edge.
module fuzz_word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_vld_o
);
    import fuzz_program_loader_pkg::*;

    logic [1:0]                cnt_q, cnt_d;
    logic [WORD_W-BYTE_W-1:0]  sh_q,  sh_d;

    // Next-state: count bytes 0..3 and shift MSB first; clr discards any partial word
    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (clr_i) begin
            cnt_d = '0;
            sh_d  = '0;
        end else if (byte_vld_i) begin
            cnt_d = cnt_q + 2'd1;
            sh_d  = {sh_q[WORD_W-2*BYTE_W-1:0], byte_i};
        end
    end

    // Byte counter and shift register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

    assign word_o     = {sh_q, byte_i};
    assign word_vld_o = byte_vld_i && (cnt_q == 2'd3);

endmodule

// File: rtl/fuzz_program_loader.sv
// Writer side of the fuzz instruction memory: zero-fills the memory, then
// writes host-streamed words from address 0 until HALT, end of stream or full.
module fuzz_program_loader #(
    parameter int MAX_INSTRUCTIONS = 256,
    parameter int ADDR_W           = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              halt_seen_o,
    output logic [1:0]        error_o,
    output logic [ADDR_W:0]   program_length_o,
    output logic [ADDR_W:0]   words_loaded_o
);
    import fuzz_program_loader_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_INSTRUCTIONS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    load_state_e         state_q,  state_d;
    logic                fin_q,    fin_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic                we_q,     we_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [WORD_W-1:0]   wdata_q,  wdata_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic                halt_q,   halt_d;
    load_err_e           err_q,    err_d;
    logic [ADDR_W:0]     plen_q,   plen_d;
    logic [ADDR_W:0]     wl_q,     wl_d;

    logic                accept;
    logic                go;
    logic [WORD_W-1:0]   word;
    logic                word_vld;

    // fin_q marks the write cycle of the final word: the FSM is still in LOAD
    // but no further byte may be taken (bytes after HALT must stay unaccepted).
    assign in_ready_o = (state_q == ST_LOAD) && !fin_q;
    assign accept     = in_valid_i && in_ready_o;
    assign go         = start_i && (state_q == ST_IDLE || state_q == ST_DONE);

    fuzz_word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (state_q != ST_LOAD),
        .byte_vld_i (accept),
        .byte_i     (in_data_i),
        .word_o     (word),
        .word_vld_o (word_vld)
    );

    // Next-state and registered-output decode for the load FSM
    always_comb begin
        state_d  = state_q;
        fin_d    = fin_q;
        wr_ptr_d = wr_ptr_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        halt_d   = halt_q;
        err_d    = err_q;
        plen_d   = plen_q;
        wl_d     = wl_q;

        case (state_q)
            ST_IDLE: begin
                fin_d    = 1'b0;
                wr_ptr_d = '0;
                halt_d   = 1'b0;
                err_d    = ERR_NONE;
                plen_d   = '0;
                wl_d     = '0;
            end
            ST_CLEAR: begin
                wdata_d = '0;
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_LOAD;
                end else begin
                    we_d   = 1'b1;
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            ST_LOAD: begin
                if (fin_q) begin
                    state_d = ST_DONE;
                end else if (word_vld) begin
                    we_d     = 1'b1;
                    addr_d   = wr_ptr_q;
                    wdata_d  = word;
                    wr_ptr_d = wr_ptr_q + ADDR_ONE;
                    wl_d     = wl_q + CNT_ONE;
                    if (word != '0) plen_d = {1'b0, wr_ptr_q} + CNT_ONE;
                    if (is_halt(word)) begin
                        halt_d = 1'b1;
                        fin_d  = 1'b1;
                        err_d  = ERR_NONE;
                    end else if (in_last_i) begin
                        fin_d  = 1'b1;
                    end else if (wr_ptr_q == LAST_ADDR) begin
                        fin_d  = 1'b1;
                        err_d  = ERR_OVERFLOW;
                    end
                end else if (accept && in_last_i) begin
                    err_d   = ERR_PARTIAL;
                    state_d = ST_DONE;
                end
            end
            default: ;
        endcase

        // A new load restarts the zero-fill at address 0 and wipes the status
        if (go) begin
            state_d  = ST_CLEAR;
            we_d     = 1'b1;
            addr_d   = '0;
            wdata_d  = '0;
            fin_d    = 1'b0;
            wr_ptr_d = '0;
            halt_d   = 1'b0;
            err_d    = ERR_NONE;
            plen_d   = '0;
            wl_d     = '0;
        end

        busy_d = (state_d == ST_CLEAR) || (state_d == ST_LOAD);
        done_d = (state_d == ST_DONE);
    end

    // State, pointer and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            fin_q    <= 1'b0;
            wr_ptr_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            halt_q   <= 1'b0;
            err_q    <= ERR_NONE;
            plen_q   <= '0;
            wl_q     <= '0;
        end else begin
            state_q  <= state_d;
            fin_q    <= fin_d;
            wr_ptr_q <= wr_ptr_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            halt_q   <= halt_d;
            err_q    <= err_d;
            plen_q   <= plen_d;
            wl_q     <= wl_d;
        end
    end

    assign mem_we_o         = we_q;
    assign mem_addr_o       = addr_q;
    assign mem_wdata_o      = wdata_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign halt_seen_o      = halt_q;
    assign error_o          = err_q;
    assign program_length_o = plen_q;
    assign words_loaded_o   = wl_q;

endmodule

// File: tb/tb_fuzz_program_loader.sv
// Bench for fuzz_program_loader: a 256-deep and a 4-deep instance share the
// byte stream; a per-load behavioural model predicts every memory write and
// the final status, and one negedge process checks every write as it happens.
module tb_fuzz_program_loader;
    import fuzz_program_loader_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0;
    logic [7:0] in_data = 8'h00;

    always #5 clk = ~clk;

    logic rdy0, we0, busy0, done0, halt0;
    logic [7:0] addr0; logic [31:0] wd0; logic [1:0] err0; logic [8:0] plen0, wl0;
    logic rdy1, we1, busy1, done1, halt1;
    logic [1:0] addr1; logic [31:0] wd1; logic [1:0] err1; logic [2:0] plen1, wl1;

    fuzz_program_loader #(.MAX_INSTRUCTIONS(256), .ADDR_W(8)) u_big (
        .clk(clk), .rst_n(rst_n), .start_i(start0), .in_valid_i(in_valid),
        .in_data_i(in_data), .in_last_i(in_last), .in_ready_o(rdy0),
        .mem_we_o(we0), .mem_addr_o(addr0), .mem_wdata_o(wd0), .busy_o(busy0),
        .done_o(done0), .halt_seen_o(halt0), .error_o(err0),
        .program_length_o(plen0), .words_loaded_o(wl0));

    fuzz_program_loader #(.MAX_INSTRUCTIONS(4), .ADDR_W(2)) u_small (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .in_valid_i(in_valid),
        .in_data_i(in_data), .in_last_i(in_last), .in_ready_o(rdy1),
        .mem_we_o(we1), .mem_addr_o(addr1), .mem_wdata_o(wd1), .busy_o(busy1),
        .done_o(done1), .halt_seen_o(halt1), .error_o(err1),
        .program_length_o(plen1), .words_loaded_o(wl1));

    int nvec = 0, nerr = 0;
    int sel = 0;
    logic rdy, dn, bsy, wem, hlt; logic [1:0] erm; logic [8:0] plm, wlm;
    assign rdy = (sel == 1) ? rdy1  : rdy0;
    assign dn  = (sel == 1) ? done1 : done0;
    assign bsy = (sel == 1) ? busy1 : busy0;
    assign wem = (sel == 1) ? we1   : we0;
    assign hlt = (sel == 1) ? halt1 : halt0;
    assign erm = (sel == 1) ? err1  : err0;
    assign plm = (sel == 1) ? {6'b0, plen1} : plen0;
    assign wlm = (sel == 1) ? {6'b0, wl1}   : wl0;

    logic [7:0]  sb[$];
    int          last_idx;
    logic [31:0] qa0[$], qd0[$], qa1[$], qd1[$];
    int          m_halt, m_err, m_plen, m_wl, m_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_w(input int d, input int a, input logic [31:0] w);
        if (d == 1) begin qa1.push_back(32'(a)); qd1.push_back(w); end
        else        begin qa0.push_back(32'(a)); qd0.push_back(w); end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) sb.push_back(w[b*8 +: 8]);
    endtask

    // Reference: zero-fill, then walk the byte list word by word.
    task automatic model(input int d, input int maxw);
        logic [31:0] w = 32'h0;
        int k = 0;
        m_halt = 0; m_err = 0; m_plen = 0; m_wl = 0; m_acc = 0;
        for (int a = 0; a < maxw; a++) push_w(d, a, 32'h0);
        for (int i = 0; i < sb.size(); i++) begin
            w = {w[23:0], sb[i]};
            m_acc = i + 1;
            if (i % 4 == 3) begin
                push_w(d, k, w);
                m_wl = k + 1;
                if (w != 0) m_plen = k + 1;
                if (w[31:24] == 8'hFF) begin m_halt = 1; break; end
                if (i == last_idx) break;
                if (k == maxw - 1) begin m_err = 2; break; end
                k++;
            end else if (i == last_idx) begin
                m_err = 1;
                break;
            end
        end
    endtask

    // Every memory write of either instance is checked against the model queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (we0) begin
                if (qa0.size() == 0) check("big_write_expected", 0, 1);
                else begin
                    check("big_waddr", {24'h0, addr0}, qa0.pop_front());
                    check("big_wdata", wd0, qd0.pop_front());
                end
            end
            if (we1) begin
                if (qa1.size() == 0) check("small_write_expected", 0, 1);
                else begin
                    check("small_waddr", {30'h0, addr1}, qa1.pop_front());
                    check("small_wdata", wd1, qd1.pop_front());
                end
            end
        end
    end

    task automatic check_reset();
        check("rst_ready", rdy0, 0); check("rst_we", we0, 0);
        check("rst_addr", addr0, 0); check("rst_wdata", wd0, 0);
        check("rst_busy", busy0, 0); check("rst_done", done0, 0);
        check("rst_halt", halt0, 0); check("rst_err", err0, 0);
        check("rst_plen", plen0, 0); check("rst_wl", wl0, 0);
        check("rst_small_we", we1, 0); check("rst_small_done", done1, 0);
    endtask

    task automatic start_clear(input int d, input int maxw);
        int nwe = 0, cyc = 0;
        bit bbad = 0;
        sel = d;
        if (d == 1) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        while (!rdy && cyc < maxw + 8) begin
            if (wem) nwe++;
            if (!bsy || dn) bbad = 1;
            @(posedge clk); #1;
            cyc++;
        end
        check("clear_writes", nwe, maxw);
        check("ready_rise_cycle", cyc, maxw);
        check("busy_in_clear", bbad, 0);
        check("ready_after_clear", rdy, 1);
    endtask

    task automatic drive(input int gap, input bit stop_n, output int acc,
                         output int since, output bit to);
        int i = 0, cyc = 0;
        bit hs;
        since = 0; to = 0;
        while (!dn && !(stop_n && i >= sb.size())) begin
            if (cyc >= 3000) begin to = 1; break; end
            if (i < sb.size() && $urandom_range(99) >= gap) begin
                in_valid = 1'b1; in_data = sb[i]; in_last = (i == last_idx);
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            hs = in_valid && rdy;
            @(posedge clk); #1;
            cyc++;
            if (hs) begin i++; since = 1; end
            else since++;
        end
        acc = i;
    endtask

    task automatic run_load(input int d, input int gap);
        int maxw = (d == 1) ? 4 : 256;
        int acc, since, qs;
        bit to;
        model(d, maxw);
        start_clear(d, maxw);
        drive(gap, 1'b0, acc, since, to);
        check("stream_timeout", to, 0);
        check("bytes_accepted", acc, m_acc);
        check("done_latency", since, (m_err == 1) ? 1 : 2);
        check("done", dn, 1);
        check("busy_at_done", bsy, 0);
        check("ready_at_done", rdy, 0);
        check("halt_seen", hlt, m_halt);
        check("error", erm, m_err);
        check("program_length", plm, m_plen);
        check("words_loaded", wlm, m_wl);
        qs = (d == 1) ? qa1.size() : qa0.size();
        check("writes_missing", qs, 0);
        in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic gen_random(input int maxw);
        int nw = $urandom_range(1, (maxw == 4) ? 6 : 10);
        int r;
        logic [7:0] op;
        sb.delete();
        for (int k = 0; k < nw; k++) begin
            r = $urandom_range(99);
            case ($urandom_range(4))
                0: op = OP_PNEW;
                1: op = OP_XOR_LOAD;
                2: op = OP_XOR_ADD;
                3: op = OP_XOR_SWAP;
                default: op = OP_EMIT;
            endcase
            if (r < 15)      push_word(32'h0);
            else if (r < 25) push_word({OP_HALT, 24'($urandom)});
            else             push_word({op, 24'($urandom)});
        end
        if (nw > maxw && $urandom_range(1) == 1) last_idx = -1;
        else last_idx = $urandom_range(4 * nw - 1);
        if (last_idx >= 0) while (sb.size() > last_idx + 1) void'(sb.pop_back());
    endtask

    initial begin
        int acc, since;
        bit to;
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // HALT stops the load; the trailing byte must not be taken
        sb.delete(); last_idx = -1;
        push_word(32'h0003_0000); push_word(32'h0A05_0700); push_word(32'hFF00_0000);
        sb.push_back(8'h11);
        run_load(0, 0);
        check("t_halt_plen", plm, 3); check("t_halt_wl", wlm, 3);
        check("t_halt_flag", hlt, 1); check("t_halt_err", erm, 0);
        check("t_halt_acc", m_acc, 12);

        // in_last on a zero word: written, length unchanged
        sb.delete(); push_word(32'h0A01_0200); push_word(32'h0); last_idx = 7;
        run_load(0, 0);
        check("t_last_plen", plm, 1); check("t_last_wl", wlm, 2);
        check("t_last_halt", hlt, 0); check("t_last_err", erm, 0);

        // in_last mid-word: PARTIAL, nothing written
        sb.delete(); sb.push_back(8'h0B); sb.push_back(8'h01); last_idx = 1;
        run_load(0, 0);
        check("t_part_err", erm, 1); check("t_part_wl", wlm, 0);

        // 4-deep memory fills without HALT or in_last: OVERFLOW
        sb.delete(); last_idx = -1;
        for (int k = 0; k < 5; k++) push_word(32'h0E00_0000);
        run_load(1, 0);
        check("t_ovf_err", erm, 2); check("t_ovf_plen", plm, 4); check("t_ovf_wl", wlm, 4);

        // Reset in the middle of LOAD, then a clean reload from address 0
        sb.delete(); last_idx = -1;
        push_word(32'h0A01_0203); sb.push_back(8'h0B); sb.push_back(8'h04);
        model(0, 256);
        start_clear(0, 256);
        drive(0, 1'b1, acc, since, to);
        check("rst_mid_acc", acc, 6);
        in_valid = 1'b0; in_last = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset();
        check("rst_mid_pending", qa0.size(), 0);
        qa0.delete(); qd0.delete();
        rst_n = 1'b1;
        sb.delete(); push_word(32'h0C00_0001); push_word(32'hFF00_0000); last_idx = -1;
        run_load(0, 0);
        check("t_reload_plen", plm, 2);

        for (int n = 0; n < 10; n++) begin
            gen_random(256);
            run_load(0, 30);
        end
        for (int n = 0; n < 12; n++) begin
            gen_random(4);
            run_load(1, 30);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
